// File: rtl/printf_line_buf.sv
// printf_line_buf
//   Collects printf bytes from CH_NUM independent sources (one per hart or CSR
//   printf port) into per-channel line buffers. A line is complete on a
//   newline/carriage-return byte, or when it reaches LINE_LEN characters.
//   Completed lines are pushed into a shared LINE_DEPTH-entry line FIFO that
//   the debug UART or the sim console drains over a valid/ready port.
//
// Ports
//   clk, rst_n      core clock, asynchronous active-low reset
//   ch_valid/data   per-channel byte strobe and byte (channel i at [i*8+:8]);
//                   no backpressure
//   line_valid/ready  FIFO head handshake
//   line_data       head line, first character in the top byte, unused bytes 0
//   line_len        character count of the head line (1..LINE_LEN)
//   line_ch         source channel of the head line
//   line_eol        1 = ended by a terminator, 0 = flushed because it was full
//   fifo_level      number of lines stored
//   drop_cnt        lines lost to a full FIFO (saturating)
//   ch_ovf          sticky per channel: a byte arrived while its line waited
//   stat_clr        synchronous clear of drop_cnt and ch_ovf
module printf_line_buf #(
  parameter int CH_NUM     = 2,
  parameter int LINE_LEN   = 64,
  parameter int LINE_DEPTH = 4,
  localparam int CHW = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int LW  = $clog2(LINE_LEN + 1),
  localparam int DW  = $clog2(LINE_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CH_NUM-1:0]     ch_valid,
  input  logic [CH_NUM*8-1:0]   ch_data,
  output logic                  line_valid,
  input  logic                  line_ready,
  output logic [LINE_LEN*8-1:0] line_data,
  output logic [LW-1:0]         line_len,
  output logic [CHW-1:0]        line_ch,
  output logic                  line_eol,
  output logic [DW-1:0]         fifo_level,
  output logic [15:0]           drop_cnt,
  output logic [CH_NUM-1:0]     ch_ovf,
  input  logic                  stat_clr
);

  localparam int BW = LINE_LEN * 8;
  localparam int AW = $clog2(LINE_DEPTH);

  typedef enum logic {ASM, PEND} ch_state_t;

  ch_state_t         state_q [CH_NUM];
  ch_state_t         state_d [CH_NUM];
  logic [LW-1:0]     len_q   [CH_NUM];
  logic [LW-1:0]     len_d   [CH_NUM];
  logic [BW-1:0]     line_q  [CH_NUM];
  logic [BW-1:0]     line_d  [CH_NUM];
  logic              eol_q   [CH_NUM];
  logic              eol_d   [CH_NUM];
  logic [CH_NUM-1:0] ovf_set;

  logic              gnt_any;
  logic [CHW-1:0]    gnt_idx;
  logic [CHW-1:0]    rr_q;

  logic              pop;
  logic              can_accept;
  logic              push;
  logic              drop;

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DW-1:0]     count;

  logic [BW-1:0]     mem_data [LINE_DEPTH];
  logic [LW-1:0]     mem_len  [LINE_DEPTH];
  logic [CHW-1:0]    mem_ch   [LINE_DEPTH];
  logic              mem_eol  [LINE_DEPTH];

  // Round-robin search over PEND channels, beginning at the pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (!gnt_any && state_q[(int'(rr_q) + k) % CH_NUM] == PEND) begin
        gnt_any = 1'b1;
        gnt_idx = CHW'((int'(rr_q) + k) % CH_NUM);
      end
    end
  end

  // A full FIFO still takes a line when its head leaves in the same cycle.
  assign line_valid = (count != '0);
  assign pop        = line_valid && line_ready;
  assign can_accept = (count != DW'(LINE_DEPTH)) || pop;
  assign push       = gnt_any && can_accept;
  assign drop       = gnt_any && !can_accept;

  // Per-channel assembly: characters fill from the top byte downwards so the
  // first character always lands in the most significant byte of the line.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      state_d[i] = state_q[i];
      len_d[i]   = len_q[i];
      line_d[i]  = line_q[i];
      eol_d[i]   = eol_q[i];
      ovf_set[i] = 1'b0;
      case (state_q[i])
        ASM: begin
          if (ch_valid[i]) begin
            if (ch_data[i*8 +: 8] == 8'h0A || ch_data[i*8 +: 8] == 8'h0D) begin
              // Empty-line terminators are dropped, so "\r\n" gives one line.
              if (len_q[i] != '0) begin
                state_d[i] = PEND;
                eol_d[i]   = 1'b1;
              end
            end else begin
              line_d[i][(LINE_LEN - 1 - int'(len_q[i])) * 8 +: 8] = ch_data[i*8 +: 8];
              len_d[i] = len_q[i] + LW'(1);
              if (len_q[i] == LW'(LINE_LEN - 1)) begin
                state_d[i] = PEND;
                eol_d[i]   = 1'b0;
              end
            end
          end
        end
        PEND: begin
          ovf_set[i] = ch_valid[i];
          // The line leaves on grant whether it was pushed or dropped.
          if (gnt_any && gnt_idx == CHW'(i)) begin
            state_d[i] = ASM;
            len_d[i]   = '0;
            line_d[i]  = '0;
            eol_d[i]   = 1'b0;
          end
        end
        default: state_d[i] = ASM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= ASM;
        len_q[i]   <= '0;
        line_q[i]  <= '0;
        eol_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        state_q[i] <= state_d[i];
        len_q[i]   <= len_d[i];
        line_q[i]  <= line_d[i];
        eol_q[i]   <= eol_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (gnt_any) begin
      rr_q <= CHW'((int'(gnt_idx) + 1) % CH_NUM);
    end
  end

  // FIFO pointers and occupancy; LINE_DEPTH is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + DW'(1);
      else if (pop && !push) count <= count - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= line_q[gnt_idx];
      mem_len[wr_ptr]  <= len_q[gnt_idx];
      mem_ch[wr_ptr]   <= gnt_idx;
      mem_eol[wr_ptr]  <= eol_q[gnt_idx];
    end
  end

  // Storage is not reset, so head fields are forced to 0 while empty.
  assign line_data  = line_valid ? mem_data[rd_ptr] : '0;
  assign line_len   = line_valid ? mem_len[rd_ptr]  : '0;
  assign line_ch    = line_valid ? mem_ch[rd_ptr]   : '0;
  assign line_eol   = line_valid ? mem_eol[rd_ptr]  : 1'b0;
  assign fifo_level = count;

  // stat_clr wins over a same-cycle drop or overflow event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      ch_ovf   <= '0;
    end else if (stat_clr) begin
      drop_cnt <= '0;
      ch_ovf   <= '0;
    end else begin
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      ch_ovf <= ch_ovf | ovf_set;
    end
  end

endmodule

// File: tb/tb_printf_line_buf.sv
// tb_printf_line_buf
//   Self-checking bench for printf_line_buf. A queue-based reference model of
//   the line buffers, arbiter and line FIFO is advanced on every clock and
//   compared against all DUT outputs on every falling edge. Directed sequences
//   with literal expectations are followed by a long randomized run.
module tb_printf_line_buf;

  localparam int CH_NUM     = 2;
  localparam int LINE_LEN   = 64;
  localparam int LINE_DEPTH = 4;
  localparam int BW         = LINE_LEN * 8;
  localparam int CHW        = 1;
  localparam int LW         = $clog2(LINE_LEN + 1);
  localparam int DW         = $clog2(LINE_DEPTH + 1);

  typedef logic [BW-1:0] wide_t;

  logic                clk;
  logic                rst_n;
  logic [CH_NUM-1:0]   ch_valid;
  logic [CH_NUM*8-1:0] ch_data;
  logic                line_valid;
  logic                line_ready;
  logic [BW-1:0]       line_data;
  logic [LW-1:0]       line_len;
  logic [CHW-1:0]      line_ch;
  logic                line_eol;
  logic [DW-1:0]       fifo_level;
  logic [15:0]         drop_cnt;
  logic [CH_NUM-1:0]   ch_ovf;
  logic                stat_clr;

  printf_line_buf #(
    .CH_NUM(CH_NUM),
    .LINE_LEN(LINE_LEN),
    .LINE_DEPTH(LINE_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ch_valid(ch_valid),
    .ch_data(ch_data),
    .line_valid(line_valid),
    .line_ready(line_ready),
    .line_data(line_data),
    .line_len(line_len),
    .line_ch(line_ch),
    .line_eol(line_eol),
    .fifo_level(fifo_level),
    .drop_cnt(drop_cnt),
    .ch_ovf(ch_ovf),
    .stat_clr(stat_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int check_count = 0;
  int fail_count  = 0;

  // Reference model state: characters collected per channel, waiting flags,
  // and the FIFO as a queue of finished lines.
  typedef struct {
    wide_t data;
    int    len;
    int    ch;
    bit    eol;
  } line_t;

  logic [7:0]        cur_m  [CH_NUM][LINE_LEN];
  int                cnt_m  [CH_NUM];
  bit                pend_m [CH_NUM];
  bit                eol_m  [CH_NUM];
  line_t             fifo_m [$];
  int                rr_m;
  int                drop_m;
  logic [CH_NUM-1:0] ovf_m;

  task automatic checkOutput(input string name, input wide_t actual, input wide_t expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < CH_NUM; c++) begin
      cnt_m[c]  = 0;
      pend_m[c] = 1'b0;
      eol_m[c]  = 1'b0;
    end
    fifo_m.delete();
    rr_m   = 0;
    drop_m = 0;
    ovf_m  = '0;
  endtask

  task automatic modelStep();
    bit    was_pend [CH_NUM];
    bit    do_pop;
    bit    accept;
    int    g;
    line_t ln;
    logic [7:0] b;
    do_pop = (fifo_m.size() != 0) && line_ready;
    accept = (fifo_m.size() < LINE_DEPTH) || do_pop;
    g = -1;
    for (int k = 0; k < CH_NUM; k++) begin
      if (g < 0 && pend_m[(rr_m + k) % CH_NUM]) g = (rr_m + k) % CH_NUM;
    end
    for (int c = 0; c < CH_NUM; c++) was_pend[c] = pend_m[c];
    if (do_pop) void'(fifo_m.pop_front());
    if (g >= 0) begin
      if (accept) begin
        ln.data = '0;
        for (int k = 0; k < cnt_m[g]; k++) ln.data[BW-1-8*k -: 8] = cur_m[g][k];
        ln.len = cnt_m[g];
        ln.ch  = g;
        ln.eol = eol_m[g];
        fifo_m.push_back(ln);
      end else if (drop_m < 65535) begin
        drop_m++;
      end
      pend_m[g] = 1'b0;
      cnt_m[g]  = 0;
      rr_m      = (g + 1) % CH_NUM;
    end
    for (int c = 0; c < CH_NUM; c++) begin
      if (ch_valid[c]) begin
        b = ch_data[c*8 +: 8];
        if (was_pend[c]) begin
          ovf_m[c] = 1'b1;
        end else if (b == 8'h0A || b == 8'h0D) begin
          if (cnt_m[c] > 0) begin
            pend_m[c] = 1'b1;
            eol_m[c]  = 1'b1;
          end
        end else begin
          cur_m[c][cnt_m[c]] = b;
          cnt_m[c]++;
          if (cnt_m[c] == LINE_LEN) begin
            pend_m[c] = 1'b1;
            eol_m[c]  = 1'b0;
          end
        end
      end
    end
    if (stat_clr) begin
      drop_m = 0;
      ovf_m  = '0;
    end
  endtask

  task automatic compareModel();
    bit    ev;
    wide_t ed;
    int    el;
    int    ec;
    bit    ee;
    ev = (fifo_m.size() != 0);
    ed = '0;
    el = 0;
    ec = 0;
    ee = 1'b0;
    if (ev) begin
      ed = fifo_m[0].data;
      el = fifo_m[0].len;
      ec = fifo_m[0].ch;
      ee = fifo_m[0].eol;
    end
    checkOutput("model_line_valid", wide_t'(line_valid), wide_t'(ev));
    checkOutput("model_fifo_level", wide_t'(fifo_level), wide_t'(fifo_m.size()));
    checkOutput("model_drop_cnt", wide_t'(drop_cnt), wide_t'(drop_m));
    checkOutput("model_ch_ovf", wide_t'(ch_ovf), wide_t'(ovf_m));
    checkOutput("model_line_data", line_data, ed);
    checkOutput("model_line_len", wide_t'(line_len), wide_t'(el));
    checkOutput("model_line_ch", wide_t'(line_ch), wide_t'(ec));
    checkOutput("model_line_eol", wide_t'(line_eol), wide_t'(ee));
  endtask

  // Model advances on the same edges the DUT does; reset acts immediately.
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else        modelStep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      compareModel();
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [CH_NUM-1:0] v, input logic [7:0] d1,
                               input logic [7:0] d0, input logic rdy, input logic clr);
    @(negedge clk);
    ch_valid   = v;
    ch_data    = {d1, d0};
    line_ready = rdy;
    stat_clr   = clr;
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus('0, 8'h00, 8'h00, rdy, 1'b0);
  endtask

  task automatic popHead();
    idleCycle(1'b1);
    idleCycle(1'b0);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n      = 1'b0;
    ch_valid   = '0;
    ch_data    = '0;
    line_ready = 1'b0;
    stat_clr   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    wide_t      all_a;
    logic [1:0] v;
    logic [7:0] d [CH_NUM];
    int         tp;
    int         rp;

    rst_n      = 1'b0;
    ch_valid   = '0;
    ch_data    = '0;
    line_ready = 1'b0;
    stat_clr   = 1'b0;
    resetDut();

    checkOutput("reset_valid", wide_t'(line_valid), '0);
    checkOutput("reset_level", wide_t'(fifo_level), '0);

    // "Hi\n" on channel 0.
    applyStimulus(2'b01, 8'h00, 8'h48, 1'b0, 1'b0);
    applyStimulus(2'b01, 8'h00, 8'h69, 1'b0, 1'b0);
    applyStimulus(2'b01, 8'h00, 8'h0A, 1'b0, 1'b0);
    idleCycle(1'b0);
    checkOutput("hi_valid_before_push", wide_t'(line_valid), '0);
    idleCycle(1'b0);
    checkOutput("hi_valid", wide_t'(line_valid), wide_t'(1'b1));
    checkOutput("hi_len", wide_t'(line_len), wide_t'(2));
    checkOutput("hi_top", wide_t'(line_data[BW-1 -: 16]), wide_t'(16'h4869));
    checkOutput("hi_rest", wide_t'(line_data[BW-17:0]), '0);
    checkOutput("hi_ch", wide_t'(line_ch), '0);
    checkOutput("hi_eol", wide_t'(line_eol), wide_t'(1'b1));

    // 64 x 'A' on channel 1, a 65th byte during PEND, then "B\n".
    resetDut();
    for (int k = 0; k < LINE_LEN; k++) applyStimulus(2'b10, 8'h41, 8'h00, 1'b0, 1'b0);
    applyStimulus(2'b10, 8'h41, 8'h00, 1'b0, 1'b0);
    idleCycle(1'b0);
    for (int k = 0; k < LINE_LEN; k++) all_a[k*8 +: 8] = 8'h41;
    checkOutput("full_len", wide_t'(line_len), wide_t'(64));
    checkOutput("full_eol", wide_t'(line_eol), '0);
    checkOutput("full_ch", wide_t'(line_ch), wide_t'(1));
    checkOutput("full_data", line_data, all_a);
    checkOutput("full_ovf", wide_t'(ch_ovf), wide_t'(2'b10));
    applyStimulus(2'b10, 8'h42, 8'h00, 1'b0, 1'b0);
    applyStimulus(2'b10, 8'h0A, 8'h00, 1'b0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("b_level", wide_t'(fifo_level), wide_t'(2));
    popHead();
    checkOutput("b_len", wide_t'(line_len), wide_t'(1));
    checkOutput("b_top", wide_t'(line_data[BW-1 -: 8]), wide_t'(8'h42));
    checkOutput("b_eol", wide_t'(line_eol), wide_t'(1'b1));

    // Simultaneous terminators on both channels: channel 0 first each time.
    resetDut();
    applyStimulus(2'b11, 8'h79, 8'h78, 1'b0, 1'b0);
    applyStimulus(2'b11, 8'h0A, 8'h0A, 1'b0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("rr_first_level", wide_t'(fifo_level), wide_t'(1));
    checkOutput("rr_first_ch", wide_t'(line_ch), '0);
    idleCycle(1'b0);
    checkOutput("rr_second_level", wide_t'(fifo_level), wide_t'(2));
    applyStimulus(2'b11, 8'h71, 8'h70, 1'b0, 1'b0);
    applyStimulus(2'b11, 8'h0A, 8'h0A, 1'b0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    popHead();
    checkOutput("rr_y_ch", wide_t'(line_ch), wide_t'(1));
    checkOutput("rr_y_top", wide_t'(line_data[BW-1 -: 8]), wide_t'(8'h79));
    popHead();
    checkOutput("rr_p_ch", wide_t'(line_ch), '0);
    checkOutput("rr_p_top", wide_t'(line_data[BW-1 -: 8]), wide_t'(8'h70));

    // Five lines into a four-deep FIFO with no consumer.
    resetDut();
    for (int n = 0; n < 5; n++) begin
      applyStimulus(2'b01, 8'h00, 8'h61, 1'b0, 1'b0);
      applyStimulus(2'b01, 8'h00, 8'h0A, 1'b0, 1'b0);
      idleCycle(1'b0);
    end
    idleCycle(1'b0);
    checkOutput("ovfl_level", wide_t'(fifo_level), wide_t'(4));
    checkOutput("ovfl_drop", wide_t'(drop_cnt), wide_t'(1));
    applyStimulus('0, 8'h00, 8'h00, 1'b0, 1'b1);
    idleCycle(1'b0);
    checkOutput("clr_drop", wide_t'(drop_cnt), '0);
    checkOutput("clr_level", wide_t'(fifo_level), wide_t'(4));

    // Push into a full FIFO while its head is popped in the same cycle.
    applyStimulus(2'b01, 8'h00, 8'h7A, 1'b0, 1'b0);
    applyStimulus(2'b01, 8'h00, 8'h0A, 1'b0, 1'b0);
    idleCycle(1'b1);
    idleCycle(1'b0);
    checkOutput("full_pp_level", wide_t'(fifo_level), wide_t'(4));
    checkOutput("full_pp_drop", wide_t'(drop_cnt), '0);
    for (int n = 0; n < 3; n++) popHead();
    checkOutput("full_pp_last", wide_t'(line_data[BW-1 -: 8]), wide_t'(8'h7A));
    checkOutput("full_pp_level1", wide_t'(fifo_level), wide_t'(1));

    // "\r\n" alone gives nothing; reset mid-line discards everything.
    resetDut();
    applyStimulus(2'b01, 8'h00, 8'h0D, 1'b0, 1'b0);
    applyStimulus(2'b01, 8'h00, 8'h0A, 1'b0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("crlf_level", wide_t'(fifo_level), '0);
    applyStimulus(2'b01, 8'h00, 8'h71, 1'b0, 1'b0);
    applyStimulus(2'b01, 8'h00, 8'h0A, 1'b0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("pre_rst_level", wide_t'(fifo_level), wide_t'(1));
    applyStimulus(2'b01, 8'h00, 8'h61, 1'b0, 1'b0);
    applyStimulus(2'b01, 8'h00, 8'h62, 1'b0, 1'b0);
    applyStimulus(2'b01, 8'h00, 8'h63, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", wide_t'(line_valid), '0);
    checkOutput("async_rst_level", wide_t'(fifo_level), '0);
    @(negedge clk);
    ch_valid = '0;
    ch_data  = '0;
    rst_n    = 1'b1;
    applyStimulus(2'b01, 8'h00, 8'h64, 1'b0, 1'b0);
    applyStimulus(2'b01, 8'h00, 8'h0A, 1'b0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("d_level", wide_t'(fifo_level), wide_t'(1));
    checkOutput("d_len", wide_t'(line_len), wide_t'(1));
    checkOutput("d_top", wide_t'(line_data[BW-1 -: 8]), wide_t'(8'h64));
    checkOutput("d_rest", wide_t'(line_data[BW-9:0]), '0);

    // Randomized traffic; segments alternate short and long lines and vary
    // how eagerly the consumer drains.
    resetDut();
    for (int seg = 0; seg < 6; seg++) begin
      tp = (seg % 2 == 1) ? 2 : 20;
      case (seg)
        0: rp = 90;
        1: rp = 20;
        2: rp = 50;
        3: rp = 0;
        4: rp = 70;
        default: rp = 100;
      endcase
      if (seg == 3) resetDut();
      for (int cyc = 0; cyc < 500; cyc++) begin
        for (int c = 0; c < CH_NUM; c++) begin
          v[c] = ($urandom_range(0, 99) < 60);
          if ($urandom_range(0, 99) < tp) d[c] = ($urandom_range(0, 1) == 1) ? 8'h0A : 8'h0D;
          else d[c] = 8'($urandom_range(0, 255));
        end
        applyStimulus(v, d[1], d[0], ($urandom_range(0, 99) < rp),
                      ($urandom_range(0, 63) == 0));
      end
    end
    idleCycle(1'b0);
    idleCycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
